// File: rtl/wb_master_interface.sv
// WISHBONE B3 master for the NIC transmit path: arbitrates for the bus, then runs a
// single or incrementing-burst cycle with a no-ACK watchdog and a post-retry back-off.
module wb_master_interface #(
    parameter int BUS_ADDRESS_WIDTH   = 32,
    parameter int BUS_DATA_WIDTH      = 32,
    parameter int GRANULARITY         = 8,
    parameter int N_BITS_BURST_LENGHT = 4,
    parameter int TIMEOUT_CYCLES      = 16,
    parameter int BACKOFF_CYCLES      = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      r_bus_arbitration_i,
    input  logic [BUS_ADDRESS_WIDTH-1:0]              address_i,
    input  logic [BUS_DATA_WIDTH-1:0]                 data_i,
    input  logic [BUS_DATA_WIDTH/GRANULARITY-1:0]     sel_i,
    input  logic                                      transaction_type_i,
    input  logic [N_BITS_BURST_LENGHT-1:0]            burst_lenght_i,
    output logic                                      message_transmitted_o,
    output logic                                      next_data_o,
    output logic                                      retry_o,
    output logic [BUS_DATA_WIDTH-1:0]                 rd_data_o,
    output logic                                      rd_valid_o,
    output logic                                      bus_req_o,
    input  logic                                      gnt_i,
    output logic                                      CYC_O,
    output logic                                      STB_O,
    output logic                                      WE_O,
    output logic [BUS_ADDRESS_WIDTH-1:0]              ADR_O,
    output logic [BUS_DATA_WIDTH-1:0]                 DAT_O,
    output logic [BUS_DATA_WIDTH/GRANULARITY-1:0]     SEL_O,
    output logic [2:0]                                CTI_O,
    output logic [1:0]                                BTE_O,
    input  logic [BUS_DATA_WIDTH-1:0]                 DAT_I,
    input  logic                                      ACK_I,
    input  logic                                      RTY_I,
    input  logic                                      ERR_I
);

    localparam int SEL_WIDTH = BUS_DATA_WIDTH / GRANULARITY;
    localparam int WD_WIDTH  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int BO_WIDTH  = (BACKOFF_CYCLES > 2) ? $clog2(BACKOFF_CYCLES) : 1;

    localparam logic [WD_WIDTH-1:0]            WD_ZERO   = {WD_WIDTH{1'b0}};
    localparam logic [WD_WIDTH-1:0]            WD_ONE    = WD_WIDTH'(1);
    localparam logic [WD_WIDTH-1:0]            WD_LAST   = WD_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [BO_WIDTH-1:0]            BO_ZERO   = {BO_WIDTH{1'b0}};
    localparam logic [BO_WIDTH-1:0]            BO_ONE    = BO_WIDTH'(1);
    localparam logic [BO_WIDTH-1:0]            BO_LAST   = BO_WIDTH'(BACKOFF_CYCLES - 1);
    localparam logic [N_BITS_BURST_LENGHT-1:0] BEAT_ZERO = {N_BITS_BURST_LENGHT{1'b0}};
    localparam logic [N_BITS_BURST_LENGHT-1:0] BEAT_ONE  = N_BITS_BURST_LENGHT'(1);
    localparam logic [BUS_ADDRESS_WIDTH-1:0]   ADR_ZERO  = {BUS_ADDRESS_WIDTH{1'b0}};
    localparam logic [BUS_ADDRESS_WIDTH-1:0]   ADR_STEP  = BUS_ADDRESS_WIDTH'(SEL_WIDTH);
    localparam logic [BUS_DATA_WIDTH-1:0]      DATA_ZERO = {BUS_DATA_WIDTH{1'b0}};
    localparam logic [SEL_WIDTH-1:0]           SEL_ZERO  = {SEL_WIDTH{1'b0}};

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQ     = 2'b01,
        XFER    = 2'b10,
        BACKOFF = 2'b11
    } state_t;

    state_t                             state_r;
    logic [N_BITS_BURST_LENGHT-1:0]     beat_cnt_r;
    logic [WD_WIDTH-1:0]                wd_cnt_r;
    logic [BO_WIDTH-1:0]                bo_cnt_r;
    logic                               bus_req_r;
    logic                               cyc_r;
    logic                               stb_r;
    logic                               we_r;
    logic [BUS_ADDRESS_WIDTH-1:0]       adr_r;
    logic [2:0]                         cti_r;
    logic                               msg_done_r;
    logic                               retry_r;
    logic [BUS_DATA_WIDTH-1:0]          rd_data_r;
    logic                               rd_valid_r;

    logic                               abort_s;
    logic                               beat_s;

    // Per-cycle termination decode: ERR > RTY > watchdog expiry > ACK.
    always_comb begin
        abort_s = 1'b0;
        beat_s  = 1'b0;
        if (state_r == XFER) begin
            abort_s = ERR_I | RTY_I | (wd_cnt_r == WD_LAST);
            beat_s  = ACK_I & ~abort_s;
        end else begin
            abort_s = 1'b0;
            beat_s  = 1'b0;
        end
    end

    // Bus FSM with all bus-facing and queue-facing registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= IDLE;
            beat_cnt_r <= BEAT_ZERO;
            wd_cnt_r   <= WD_ZERO;
            bo_cnt_r   <= BO_ZERO;
            bus_req_r  <= 1'b0;
            cyc_r      <= 1'b0;
            stb_r      <= 1'b0;
            we_r       <= 1'b0;
            adr_r      <= ADR_ZERO;
            cti_r      <= CTI_CLASSIC;
            msg_done_r <= 1'b0;
            retry_r    <= 1'b0;
            rd_data_r  <= DATA_ZERO;
            rd_valid_r <= 1'b0;
        end else begin
            msg_done_r <= 1'b0;
            retry_r    <= 1'b0;
            rd_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (r_bus_arbitration_i) begin
                        state_r   <= REQ;
                        bus_req_r <= 1'b1;
                    end
                end
                REQ: begin
                    if (gnt_i) begin
                        state_r    <= XFER;
                        cyc_r      <= 1'b1;
                        stb_r      <= 1'b1;
                        adr_r      <= address_i;
                        we_r       <= transaction_type_i;
                        beat_cnt_r <= burst_lenght_i;
                        wd_cnt_r   <= WD_ZERO;
                        cti_r      <= (burst_lenght_i == BEAT_ZERO) ? CTI_CLASSIC : CTI_INCR;
                    end else if (!r_bus_arbitration_i) begin
                        state_r   <= IDLE;
                        bus_req_r <= 1'b0;
                    end
                end
                XFER: begin
                    if (abort_s) begin
                        state_r   <= BACKOFF;
                        bus_req_r <= 1'b0;
                        cyc_r     <= 1'b0;
                        stb_r     <= 1'b0;
                        cti_r     <= CTI_CLASSIC;
                        retry_r   <= 1'b1;
                        bo_cnt_r  <= BO_ZERO;
                    end else if (beat_s) begin
                        wd_cnt_r <= WD_ZERO;
                        if (!we_r) begin
                            rd_data_r  <= DAT_I;
                            rd_valid_r <= 1'b1;
                        end
                        if (beat_cnt_r == BEAT_ZERO) begin
                            state_r    <= IDLE;
                            bus_req_r  <= 1'b0;
                            cyc_r      <= 1'b0;
                            stb_r      <= 1'b0;
                            cti_r      <= CTI_CLASSIC;
                            msg_done_r <= 1'b1;
                        end else begin
                            beat_cnt_r <= beat_cnt_r - BEAT_ONE;
                            adr_r      <= adr_r + ADR_STEP;
                            // The beat that leaves the counter at zero is the last one.
                            cti_r      <= (beat_cnt_r == BEAT_ONE) ? CTI_END : CTI_INCR;
                        end
                    end else begin
                        wd_cnt_r <= wd_cnt_r + WD_ONE;
                    end
                end
                BACKOFF: begin
                    if (bo_cnt_r == BO_LAST) begin
                        state_r <= IDLE;
                    end else begin
                        bo_cnt_r <= bo_cnt_r + BO_ONE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    bus_req_r <= 1'b0;
                    cyc_r     <= 1'b0;
                    stb_r     <= 1'b0;
                    cti_r     <= CTI_CLASSIC;
                end
            endcase
        end
    end

    // Write word and lanes pass straight through, gated off while no strobe is active.
    assign DAT_O = stb_r ? data_i : DATA_ZERO;
    assign SEL_O = stb_r ? sel_i  : SEL_ZERO;

    assign next_data_o           = beat_s;
    assign message_transmitted_o = msg_done_r;
    assign retry_o               = retry_r;
    assign rd_data_o             = rd_data_r;
    assign rd_valid_o            = rd_valid_r;
    assign bus_req_o             = bus_req_r;
    assign CYC_O                 = cyc_r;
    assign STB_O                 = stb_r;
    assign WE_O                  = we_r;
    assign ADR_O                 = adr_r;
    assign CTI_O                 = cti_r;
    assign BTE_O                 = 2'b00;

endmodule

// File: tb/tb_wb_master_interface.sv
// Directed self-checking bench for wb_master_interface.
module tb_wb_master_interface;

    logic        clk = 1'b0;
    logic        rst;
    logic        r_bus_arbitration_i;
    logic [31:0] address_i;
    logic [31:0] data_i;
    logic [3:0]  sel_i;
    logic        transaction_type_i;
    logic [3:0]  burst_lenght_i;
    logic        message_transmitted_o;
    logic        next_data_o;
    logic        retry_o;
    logic [31:0] rd_data_o;
    logic        rd_valid_o;
    logic        bus_req_o;
    logic        gnt_i;
    logic        CYC_O, STB_O, WE_O;
    logic [31:0] ADR_O;
    logic [31:0] DAT_O;
    logic [3:0]  SEL_O;
    logic [2:0]  CTI_O;
    logic [1:0]  BTE_O;
    logic [31:0] DAT_I;
    logic        ACK_I, RTY_I, ERR_I;

    int n_cmp = 0;
    int n_err = 0;

    wb_master_interface dut (
        .clk                   (clk),
        .rst                   (rst),
        .r_bus_arbitration_i   (r_bus_arbitration_i),
        .address_i             (address_i),
        .data_i                (data_i),
        .sel_i                 (sel_i),
        .transaction_type_i    (transaction_type_i),
        .burst_lenght_i        (burst_lenght_i),
        .message_transmitted_o (message_transmitted_o),
        .next_data_o           (next_data_o),
        .retry_o               (retry_o),
        .rd_data_o             (rd_data_o),
        .rd_valid_o            (rd_valid_o),
        .bus_req_o             (bus_req_o),
        .gnt_i                 (gnt_i),
        .CYC_O                 (CYC_O),
        .STB_O                 (STB_O),
        .WE_O                  (WE_O),
        .ADR_O                 (ADR_O),
        .DAT_O                 (DAT_O),
        .SEL_O                 (SEL_O),
        .CTI_O                 (CTI_O),
        .BTE_O                 (BTE_O),
        .DAT_I                 (DAT_I),
        .ACK_I                 (ACK_I),
        .RTY_I                 (RTY_I),
        .ERR_I                 (ERR_I)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".bus_req"}, bus_req_o, 1'b0);
        check({tag, ".cyc"}, CYC_O, 1'b0);
        check({tag, ".stb"}, STB_O, 1'b0);
        check({tag, ".we"}, WE_O, 1'b0);
        check({tag, ".adr"}, ADR_O, 32'h0);
        check({tag, ".cti"}, CTI_O, 3'b000);
        check({tag, ".bte"}, BTE_O, 2'b00);
        check({tag, ".dat_o"}, DAT_O, 32'h0);
        check({tag, ".sel_o"}, SEL_O, 4'h0);
        check({tag, ".msg"}, message_transmitted_o, 1'b0);
        check({tag, ".next"}, next_data_o, 1'b0);
        check({tag, ".retry"}, retry_o, 1'b0);
        check({tag, ".rd_data"}, rd_data_o, 32'h0);
        check({tag, ".rd_valid"}, rd_valid_o, 1'b0);
    endtask

    initial begin
        rst = 1'b0; r_bus_arbitration_i = 1'b0; address_i = 32'h0;
        data_i = 32'hFFFF_FFFF; sel_i = 4'hF; transaction_type_i = 1'b0;
        burst_lenght_i = 4'h0; gnt_i = 1'b0; DAT_I = 32'h0;
        ACK_I = 1'b0; RTY_I = 1'b0; ERR_I = 1'b0;

        // Reset state
        repeat (3) next_cycle();
        #1;
        check_all_zero("reset");

        // Single write
        next_cycle();
        rst = 1'b1;
        next_cycle();
        r_bus_arbitration_i = 1'b1; address_i = 32'h100; data_i = 32'hDEAD_BEEF;
        sel_i = 4'hF; transaction_type_i = 1'b1; burst_lenght_i = 4'h0;
        #1;
        check("w1.idle_bus_req", bus_req_o, 1'b0);
        next_cycle();
        gnt_i = 1'b1;
        #1;
        check("w1.req_bus_req", bus_req_o, 1'b1);
        check("w1.req_cyc", CYC_O, 1'b0);
        next_cycle();
        gnt_i = 1'b0; ACK_I = 1'b1; r_bus_arbitration_i = 1'b0;
        #1;
        check("w1.cyc", CYC_O, 1'b1);
        check("w1.stb", STB_O, 1'b1);
        check("w1.we", WE_O, 1'b1);
        check("w1.adr", ADR_O, 32'h100);
        check("w1.cti", CTI_O, 3'b000);
        check("w1.dat_o", DAT_O, 32'hDEAD_BEEF);
        check("w1.sel_o", SEL_O, 4'hF);
        check("w1.next", next_data_o, 1'b1);
        check("w1.msg_early", message_transmitted_o, 1'b0);
        next_cycle();
        ACK_I = 1'b0;
        #1;
        check("w1.msg", message_transmitted_o, 1'b1);
        check("w1.cyc_low", CYC_O, 1'b0);
        check("w1.next_low", next_data_o, 1'b0);
        check("w1.retry", retry_o, 1'b0);
        next_cycle();
        #1;
        check("w1.msg_one_shot", message_transmitted_o, 1'b0);

        // Four-beat write burst with ACK held high
        r_bus_arbitration_i = 1'b1; gnt_i = 1'b1; address_i = 32'h100;
        transaction_type_i = 1'b1; burst_lenght_i = 4'h3; data_i = 32'h1000;
        next_cycle();
        ACK_I = 1'b1;
        #1;
        check("b4.bus_req", bus_req_o, 1'b1);
        next_cycle();
        r_bus_arbitration_i = 1'b0; gnt_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            data_i = 32'h1000 + i;
            #1;
            check($sformatf("b4.adr%0d", i), ADR_O, 32'h100 + 4 * i);
            check($sformatf("b4.cti%0d", i), CTI_O, (i == 3) ? 3'b111 : 3'b010);
            check($sformatf("b4.next%0d", i), next_data_o, 1'b1);
            check($sformatf("b4.dat%0d", i), DAT_O, 32'h1000 + i);
            check($sformatf("b4.msg%0d", i), message_transmitted_o, 1'b0);
            next_cycle();
        end
        ACK_I = 1'b0;
        #1;
        check("b4.msg", message_transmitted_o, 1'b1);
        check("b4.cyc_low", CYC_O, 1'b0);
        next_cycle();

        // RTY together with ACK on beat 2, then back-off with request held
        r_bus_arbitration_i = 1'b1; gnt_i = 1'b1; address_i = 32'h200; burst_lenght_i = 4'h3;
        next_cycle();
        next_cycle();
        gnt_i = 1'b0; ACK_I = 1'b1;
        #1;
        check("rty.beat1_next", next_data_o, 1'b1);
        check("rty.beat1_adr", ADR_O, 32'h200);
        next_cycle();
        RTY_I = 1'b1;
        #1;
        check("rty.beat2_next", next_data_o, 1'b0);
        check("rty.beat2_adr", ADR_O, 32'h204);
        check("rty.beat2_retry", retry_o, 1'b0);
        next_cycle();
        ACK_I = 1'b0; RTY_I = 1'b0;
        #1;
        check("rty.retry", retry_o, 1'b1);
        check("rty.cyc", CYC_O, 1'b0);
        check("rty.stb", STB_O, 1'b0);
        check("rty.msg", message_transmitted_o, 1'b0);
        check("rty.next", next_data_o, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("rty.hold_bus_req%0d", i), bus_req_o, 1'b0);
            if (i == 1) check("rty.retry_one_shot", retry_o, 1'b0);
            next_cycle();
        end
        #1;
        check("rty.req_resumed", bus_req_o, 1'b1);

        // Slave never responds: watchdog abort after 16 XFER cycles
        gnt_i = 1'b1;
        next_cycle();
        gnt_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            check($sformatf("wd.cyc%0d", i), CYC_O, 1'b1);
            check($sformatf("wd.retry%0d", i), retry_o, 1'b0);
            next_cycle();
        end
        r_bus_arbitration_i = 1'b0;
        #1;
        check("wd.retry", retry_o, 1'b1);
        check("wd.cyc_low", CYC_O, 1'b0);
        repeat (5) next_cycle();

        // Two-beat read burst
        r_bus_arbitration_i = 1'b1; gnt_i = 1'b1; address_i = 32'h300;
        transaction_type_i = 1'b0; burst_lenght_i = 4'h1;
        next_cycle();
        next_cycle();
        r_bus_arbitration_i = 1'b0; gnt_i = 1'b0; ACK_I = 1'b1; DAT_I = 32'h11;
        #1;
        check("rd.we", WE_O, 1'b0);
        check("rd.cti0", CTI_O, 3'b010);
        check("rd.adr0", ADR_O, 32'h300);
        check("rd.next0", next_data_o, 1'b1);
        check("rd.valid_early", rd_valid_o, 1'b0);
        next_cycle();
        DAT_I = 32'h22;
        #1;
        check("rd.valid0", rd_valid_o, 1'b1);
        check("rd.data0", rd_data_o, 32'h11);
        check("rd.adr1", ADR_O, 32'h304);
        check("rd.cti1", CTI_O, 3'b111);
        next_cycle();
        ACK_I = 1'b0;
        #1;
        check("rd.valid1", rd_valid_o, 1'b1);
        check("rd.data1", rd_data_o, 32'h22);
        check("rd.msg", message_transmitted_o, 1'b1);
        next_cycle();
        #1;
        check("rd.valid_one_shot", rd_valid_o, 1'b0);
        check("rd.data_hold", rd_data_o, 32'h22);

        // Reset asserted mid-burst
        r_bus_arbitration_i = 1'b1; gnt_i = 1'b1; address_i = 32'h400;
        transaction_type_i = 1'b1; burst_lenght_i = 4'h3;
        next_cycle();
        next_cycle();
        gnt_i = 1'b0; ACK_I = 1'b1;
        next_cycle();
        ACK_I = 1'b0; rst = 1'b0; r_bus_arbitration_i = 1'b0;
        #1;
        check("rst.cyc_before", CYC_O, 1'b1);
        next_cycle();
        rst = 1'b1;
        #1;
        check_all_zero("rst");
        next_cycle();
        #1;
        check("rst.msg_after", message_transmitted_o, 1'b0);
        check("rst.retry_after", retry_o, 1'b0);

        // Normal operation after reset release
        r_bus_arbitration_i = 1'b1; gnt_i = 1'b1; address_i = 32'h500;
        burst_lenght_i = 4'h0; data_i = 32'hCAFE_0001;
        next_cycle();
        #1;
        check("post.bus_req", bus_req_o, 1'b1);
        next_cycle();
        r_bus_arbitration_i = 1'b0; gnt_i = 1'b0; ACK_I = 1'b1;
        #1;
        check("post.adr", ADR_O, 32'h500);
        check("post.cti", CTI_O, 3'b000);
        check("post.next", next_data_o, 1'b1);
        next_cycle();
        ACK_I = 1'b0;
        #1;
        check("post.msg", message_transmitted_o, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
